// File: rtl/wb_master_arbiter.sv
// Two-requester Wishbone master arbiter: round-robin ownership with bounded tenure (MAX_BURST beats).
// Optional hung-slave abort is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_master_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        m0_wb_CYC_I,
  input  logic        m0_wb_STB_I,
  input  logic        m0_wb_LOCK_I,
  input  logic        m0_wb_WE_I,
  input  logic [3:0]  m0_wb_SEL_I,
  input  logic [31:0] m0_wb_ADR_I,
  input  logic [31:0] m0_wb_DAT_I,
  output logic        m0_wb_ACK_O,
  output logic        m0_wb_ERR_O,
  output logic [31:0] m0_wb_DAT_O,
  input  logic        m1_wb_CYC_I,
  input  logic        m1_wb_STB_I,
  input  logic        m1_wb_LOCK_I,
  input  logic        m1_wb_WE_I,
  input  logic [3:0]  m1_wb_SEL_I,
  input  logic [31:0] m1_wb_ADR_I,
  input  logic [31:0] m1_wb_DAT_I,
  output logic        m1_wb_ACK_O,
  output logic        m1_wb_ERR_O,
  output logic [31:0] m1_wb_DAT_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic [31:0] p_wb_DAT_I,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t     state;
  logic       last_owner;
  logic [7:0] beat_cnt;
  logic [7:0] beat_cnt_nxt;
  logic       own0;
  logic       own1;
  logic       beat;
  logic       cnt_hit;
  logic       owner_cyc;
  logic       other_cyc;
  logic       timeout_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    if (cnt >= MAX_B) return MAX_B;
    return cnt + 8'd1;
  endfunction

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  always_comb begin
    p_wb_CYC_O  = 1'b0;
    p_wb_STB_O  = 1'b0;
    p_wb_LOCK_O = 1'b0;
    p_wb_WE_O   = 1'b0;
    p_wb_SEL_O  = 4'h0;
    p_wb_ADR_O  = 32'h0;
    p_wb_DAT_O  = 32'h0;
    if (own0) begin
      p_wb_CYC_O  = m0_wb_CYC_I;
      p_wb_STB_O  = m0_wb_STB_I;
      p_wb_LOCK_O = m0_wb_LOCK_I;
      p_wb_WE_O   = m0_wb_WE_I;
      p_wb_SEL_O  = m0_wb_SEL_I;
      p_wb_ADR_O  = m0_wb_ADR_I;
      p_wb_DAT_O  = m0_wb_DAT_I;
    end else if (own1) begin
      p_wb_CYC_O  = m1_wb_CYC_I;
      p_wb_STB_O  = m1_wb_STB_I;
      p_wb_LOCK_O = m1_wb_LOCK_I;
      p_wb_WE_O   = m1_wb_WE_I;
      p_wb_SEL_O  = m1_wb_SEL_I;
      p_wb_ADR_O  = m1_wb_ADR_I;
      p_wb_DAT_O  = m1_wb_DAT_I;
    end
  end

  // Read data is shared bus data; only the handshake is steered to the owner.
  assign m0_wb_ACK_O = own0 & p_wb_ACK_I;
  assign m1_wb_ACK_O = own1 & p_wb_ACK_I;
  assign m0_wb_ERR_O = own0 & (p_wb_ERR_I | timeout_hit);
  assign m1_wb_ERR_O = own1 & (p_wb_ERR_I | timeout_hit);
  assign m0_wb_DAT_O = p_wb_DAT_I;
  assign m1_wb_DAT_O = p_wb_DAT_I;

  assign owner_cyc    = own0 ? m0_wb_CYC_I : m1_wb_CYC_I;
  assign other_cyc    = own0 ? m1_wb_CYC_I : m0_wb_CYC_I;
  assign beat         = p_wb_STB_O & (p_wb_ACK_I | p_wb_ERR_I);
  assign beat_cnt_nxt = sat_inc(beat_cnt);
  assign cnt_hit      = beat && (beat_cnt_nxt >= MAX_B);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [7:0] wait_cnt;

  assign timeout_hit = p_wb_STB_O && !p_wb_ACK_I && !p_wb_ERR_I && ((wait_cnt + 8'd1) >= TMO);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= 8'd0;
    end else if (state == IDLE || beat || timeout_hit) begin
      wait_cnt <= 8'd0;
    end else if (p_wb_STB_O) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  // No abort path in this build: a slave that never answers holds the bus.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      beat_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= 8'd0;
          if (m0_wb_CYC_I && (!m1_wb_CYC_I || last_owner)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1_wb_CYC_I) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!owner_cyc || timeout_hit || (cnt_hit && !p_wb_LOCK_O && other_cyc)) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= own1;
            beat_cnt   <= 8'd0;
          end else if (cnt_hit && !p_wb_LOCK_O) begin
            // Tenure expired but nobody else wants the bus: start a fresh tenure in place.
            beat_cnt <= 8'd0;
          end else if (beat) begin
            beat_cnt <= beat_cnt_nxt;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule
